// File: rtl/key_remap.sv
// Maps physical note buttons to logical notes through a loadable permutation table.
// A newly loaded table is checked for being a bijection before it is used; otherwise identity applies.
module key_remap #(
    parameter int NKEYS = 8
) (
    input  logic             slow_clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [2:0]       perm0,
    input  logic [2:0]       perm1,
    input  logic [2:0]       perm2,
    input  logic [2:0]       perm3,
    input  logic [2:0]       perm4,
    input  logic [2:0]       perm5,
    input  logic [2:0]       perm6,
    input  logic [2:0]       perm7,
    input  logic [NKEYS-1:0] pose_buts,
    output logic [2:0]       note_idx,
    output logic             note_valid,
    output logic             perm_ok,
    output logic             busy,
    output logic             multi_press,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        READY = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [7:0][2:0] IDENTITY = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    state_t          state_q, state_d;
    logic [7:0][2:0] table_q, table_d;
    logic [7:0]      seen_q, seen_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      note_idx_q, note_idx_d;
    logic            note_valid_q, note_valid_d;
    logic            multi_q, multi_d;

    logic [7:0][2:0] perm_in;
    logic [2:0]      press_idx;
    logic            press_any;
    logic            press_multi;
    logic [2:0]      cur_entry;

    assign perm_in = {perm7, perm6, perm5, perm4, perm3, perm2, perm1, perm0};
    assign cur_entry = table_q[idx_q];

    always_comb begin
        press_idx = 3'd0;
        for (int j = 0; j < NKEYS; j++) begin
            if (pose_buts[j]) press_idx = 3'(j);
        end
        press_any   = |pose_buts;
        // x & (x-1) clears the lowest set bit; anything left means two or more buttons.
        press_multi = |(pose_buts & (pose_buts - NKEYS'(1)));
    end

    always_comb begin
        state_d      = state_q;
        table_d      = table_q;
        seen_d       = seen_q;
        idx_d        = idx_q;
        note_idx_d   = note_idx_q;
        note_valid_d = 1'b0;
        multi_d      = 1'b0;

        if (load) begin
            // A load pre-empts any press in the same cycle and restarts validation.
            table_d = perm_in;
            seen_d  = 8'd0;
            idx_d   = 3'd0;
            state_d = CHECK;
        end else begin
            case (state_q)
                CHECK: begin
                    if (seen_q[cur_entry]) begin
                        state_d = ERR;
                    end else begin
                        seen_d[cur_entry] = 1'b1;
                        idx_d             = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = READY;
                    end
                end
                default: begin
                    if (press_multi) begin
                        multi_d = 1'b1;
                    end else if (press_any) begin
                        note_valid_d = 1'b1;
                        note_idx_d   = (state_q == READY) ? table_q[press_idx] : press_idx;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge slow_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            table_q      <= IDENTITY;
            seen_q       <= 8'd0;
            idx_q        <= 3'd0;
            note_idx_q   <= 3'd0;
            note_valid_q <= 1'b0;
            multi_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            table_q      <= table_d;
            seen_q       <= seen_d;
            idx_q        <= idx_d;
            note_idx_q   <= note_idx_d;
            note_valid_q <= note_valid_d;
            multi_q      <= multi_d;
        end
    end

    assign note_idx    = note_idx_q;
    assign note_valid  = note_valid_q;
    assign multi_press = multi_q;
    assign busy        = (state_q == CHECK);
    assign perm_ok     = (state_q == READY);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_key_remap.sv
// Directed bench for key_remap: identity, reversed/rotated/duplicate tables, multi-press, sweep, reset mid-check.
module tb_key_remap;

    logic       slow_clk;
    logic       rst_n;
    logic       load;
    logic [2:0] perm [8];
    logic [7:0] pose_buts;
    logic [2:0] note_idx;
    logic       note_valid;
    logic       perm_ok;
    logic       busy;
    logic       multi_press;
    logic [1:0] dbg_state;

    int n_cmp;
    int n_err;

    key_remap #(.NKEYS(8)) dut (
        .slow_clk    (slow_clk),
        .rst_n       (rst_n),
        .load        (load),
        .perm0       (perm[0]),
        .perm1       (perm[1]),
        .perm2       (perm[2]),
        .perm3       (perm[3]),
        .perm4       (perm[4]),
        .perm5       (perm[5]),
        .perm6       (perm[6]),
        .perm7       (perm[7]),
        .pose_buts   (pose_buts),
        .note_idx    (note_idx),
        .note_valid  (note_valid),
        .perm_ok     (perm_ok),
        .busy        (busy),
        .multi_press (multi_press),
        .dbg_state   (dbg_state)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_idx, input logic e_valid,
                           input logic e_ok, input logic e_busy, input logic e_multi);
        chk({tag, ".note_idx"}, {5'd0, note_idx}, {5'd0, e_idx});
        chk({tag, ".note_valid"}, {7'd0, note_valid}, {7'd0, e_valid});
        chk({tag, ".perm_ok"}, {7'd0, perm_ok}, {7'd0, e_ok});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
        chk({tag, ".multi_press"}, {7'd0, multi_press}, {7'd0, e_multi});
    endtask

    task automatic set_perm(input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2,
                            input logic [2:0] p3, input logic [2:0] p4, input logic [2:0] p5,
                            input logic [2:0] p6, input logic [2:0] p7);
        perm[0] = p0; perm[1] = p1; perm[2] = p2; perm[3] = p3;
        perm[4] = p4; perm[5] = p5; perm[6] = p6; perm[7] = p7;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        load      = 1'b0;
        pose_buts = 8'd0;
        set_perm(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);

        // Reset state
        #12;
        chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.state", {6'd0, dbg_state}, 8'd0);
        #5 rst_n = 1'b1;
        @(negedge slow_clk);

        // Identity mapping straight after reset; first edge is a normal cycle
        pose_buts = 8'b0000_0100;
        tick();
        chk_out("ident_press", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        pose_buts = 8'd0;
        tick();
        chk_out("ident_hold", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Multi-press in IDLE
        pose_buts = 8'b1000_0001;
        tick();
        chk_out("idle_multi", 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        pose_buts = 8'd0;

        // Reversed table: busy for exactly 8 cycles, presses ignored during CHECK
        set_perm(3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        set_perm(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        chk_out("rev_check0", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 8; c++) begin
            pose_buts = (c % 2 == 1) ? 8'b0000_0001 : 8'b0000_0011;
            tick();
            chk_out($sformatf("rev_check%0d", c), 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        pose_buts = 8'd0;
        tick();
        chk_out("rev_ready", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rev_ready.state", {6'd0, dbg_state}, 8'd2);

        pose_buts = 8'b0000_0001;
        tick();
        chk_out("rev_b0", 3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        pose_buts = 8'b1000_0000;
        tick();
        chk_out("rev_b7", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Multi-press in READY: note_idx unchanged
        pose_buts = 8'b0000_0011;
        tick();
        chk_out("ready_multi", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        pose_buts = 8'd0;
        tick();
        chk_out("ready_idle", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Walking one-hot on consecutive cycles
        for (int j = 0; j < 8; j++) begin
            pose_buts = 8'd1 << j;
            tick();
            chk_out($sformatf("sweep%0d", j), 3'(7 - j), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        pose_buts = 8'd0;

        // Load coincident with press: load wins
        set_perm(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0);
        load = 1'b1;
        pose_buts = 8'b0000_0001;
        tick();
        load = 1'b0;
        pose_buts = 8'd0;
        chk_out("load_vs_press", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();

        // Reload mid-CHECK with a duplicate table: ERR on the 5th CHECK cycle
        set_perm(3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd6, 3'd7);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk_out("dup_check0", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 5; c++) begin
            tick();
            chk_out($sformatf("dup_check%0d", c), 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        chk_out("dup_err", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dup_err.state", {6'd0, dbg_state}, 8'd3);
        pose_buts = 8'b0001_0000;
        tick();
        chk_out("err_press", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        pose_buts = 8'd0;

        // Rotated table: button i -> note (i+1)%8
        set_perm(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        chk_out("rot_ready", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        pose_buts = 8'b0000_0100;
        tick();
        chk_out("rot_b2", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        pose_buts = 8'b1000_0000;
        tick();
        chk_out("rot_b7", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        pose_buts = 8'd0;

        // Reset in the 3rd CHECK cycle: outputs clear immediately, identity afterwards
        set_perm(3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0);
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        chk("midrst.busy_before", {7'd0, busy}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("midrst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.state", {6'd0, dbg_state}, 8'd0);
        #3 rst_n = 1'b1;
        pose_buts = 8'b0010_0000;
        tick();
        chk_out("post_rst_press", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        pose_buts = 8'd0;
        tick();
        chk_out("post_rst_idle", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
